// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: round-robin sharing of the registered-read instruction ROM between IF and LS
module rom_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ROM_BYTES    = 8192,
  parameter int ERRCNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   if_req_addr,
  output logic                    if_rsp_valid,
  input  logic                    if_rsp_ready,
  output logic [DATA_WIDTH-1:0]   if_rsp_data,
  output logic                    if_rsp_err,
  input  logic                    ls_req_valid,
  output logic                    ls_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ls_req_addr,
  output logic                    ls_rsp_valid,
  input  logic                    ls_rsp_ready,
  output logic [DATA_WIDTH-1:0]   ls_rsp_data,
  output logic                    ls_rsp_err,
  output logic                    rom_en,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [DATA_WIDTH-1:0]   rom_data,
  output logic [ERRCNT_WIDTH-1:0] err_count
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_nxt;
  logic owner_ls, err_q, last_ls;
  logic grant_if, grant_ls, acc, oob;
  logic [ADDR_WIDTH-1:0] acc_addr;
  // grant: in IDLE a lone requester wins, on a tie the one not granted last time wins
  always_comb begin
    grant_if = !reset && state == IDLE && if_req_valid && (!ls_req_valid || last_ls);
    grant_ls = !reset && state == IDLE && ls_req_valid && (!if_req_valid || !last_ls);
    acc      = grant_if || grant_ls;
    acc_addr = grant_ls ? ls_req_addr : if_req_addr;
    oob      = acc_addr >= ADDR_WIDTH'(ROM_BYTES);
  end
  // state register plus per-transaction owner, error flag, fairness and error count
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner_ls  <= 1'b0;
      err_q     <= 1'b0;
      last_ls   <= 1'b1;
      err_count <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        owner_ls <= grant_ls;
        err_q    <= oob;
        last_ls  <= grant_ls;
        if (oob && !(&err_count)) err_count <= err_count + ERRCNT_WIDTH'(1);
      end
    end
  end
  // next state: accept moves to RESP, owner's response handshake returns to IDLE
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = acc ? RESP : IDLE;
    else state_nxt = (owner_ls ? ls_rsp_ready : if_rsp_ready) ? IDLE : RESP;
  end
  // outputs: ROM is only enabled on an in-bounds accept, so its data is stable through RESP
  always_comb begin
    if_req_ready = grant_if;
    ls_req_ready = grant_ls;
    rom_en       = acc && !oob;
    rom_addr     = rom_en ? acc_addr : '0;
    if_rsp_valid = state == RESP && !owner_ls;
    ls_rsp_valid = state == RESP && owner_ls;
    if_rsp_err   = if_rsp_valid && err_q;
    ls_rsp_err   = ls_rsp_valid && err_q;
    if_rsp_data  = (if_rsp_valid && !err_q) ? rom_data : '0;
    ls_rsp_data  = (ls_rsp_valid && !err_q) ? rom_data : '0;
  end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: scoreboard bench with a word-array ROM and a transaction-level reference model
module tb_rom_port_arbiter;
  localparam int EW = 8;
  localparam logic [EW-1:0] EMAX = '1;
  logic clk = 0, reset = 1;
  logic if_req_valid = 0, if_rsp_ready = 0, ls_req_valid = 0, ls_rsp_ready = 0;
  logic [31:0] if_req_addr = 0, ls_req_addr = 0;
  logic if_req_ready, if_rsp_valid, if_rsp_err, ls_req_ready, ls_rsp_valid, ls_rsp_err, rom_en;
  logic [31:0] if_rsp_data, ls_rsp_data, rom_addr, rom_data;
  logic [EW-1:0] err_count;
  logic [31:0] mem [2048];
  logic [31:0] rom_q;
  int n_chk = 0, n_fail = 0;

  typedef struct {bit ls; logic [31:0] data; bit err;} rsp_t;
  rsp_t q[$];
  rsp_t e;
  bit last_ls = 1, exp_if, exp_ls, busy, m_oob;
  logic [EW-1:0] ecnt = 0;
  logic [31:0] a;

  rom_port_arbiter #(.ERRCNT_WIDTH(EW)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_q <= mem[rom_addr[12:2]];
  assign rom_data = rom_q;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_if_ready", if_req_ready, 0);
      chk("rst_ls_ready", ls_req_ready, 0);
      chk("rst_rom_en", rom_en, 0);
      q.delete();
      last_ls = 1;
      ecnt = 0;
    end else begin
      busy = q.size() != 0;
      chk("err_count", err_count, ecnt);
      exp_if = !busy && if_req_valid && (!ls_req_valid || last_ls);
      exp_ls = !busy && ls_req_valid && !exp_if;
      chk("if_req_ready", if_req_ready, exp_if);
      chk("ls_req_ready", ls_req_ready, exp_ls);
      if (busy) begin
        e = q[0];
        chk("if_rsp_valid", if_rsp_valid, !e.ls);
        chk("ls_rsp_valid", ls_rsp_valid, e.ls);
        chk("if_rsp_data", if_rsp_data, e.ls ? 32'h0 : e.data);
        chk("ls_rsp_data", ls_rsp_data, e.ls ? e.data : 32'h0);
        chk("if_rsp_err", if_rsp_err, !e.ls && e.err);
        chk("ls_rsp_err", ls_rsp_err, e.ls && e.err);
        chk("rom_en_resp", rom_en, 0);
        if (e.ls ? ls_rsp_ready : if_rsp_ready) void'(q.pop_front());
      end else begin
        chk("idle_if_rsp_valid", if_rsp_valid, 0);
        chk("idle_ls_rsp_valid", ls_rsp_valid, 0);
        if (exp_if || exp_ls) begin
          a = exp_ls ? ls_req_addr : if_req_addr;
          m_oob = a >= 32'd8192;
          chk("rom_en", rom_en, !m_oob);
          chk("rom_addr", rom_addr, m_oob ? 32'h0 : a);
          q.push_back('{exp_ls, m_oob ? 32'h0 : mem[a[12:2]], m_oob});
          last_ls = exp_ls;
          if (m_oob && ecnt != EMAX) ecnt++;
        end else begin
          chk("rom_en_idle", rom_en, 0);
          chk("rom_addr_idle", rom_addr, 0);
        end
      end
    end
  end

  task automatic cyc(input bit iv, input logic [31:0] ia, input bit ir,
                     input bit lv, input logic [31:0] la, input bit lr);
    if_req_valid = iv; if_req_addr = ia; if_rsp_ready = ir;
    ls_req_valid = lv; ls_req_addr = la; ls_rsp_ready = lr;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 5))
      0: return 32'h1FFC;
      1: return 32'h2000;
      2: return 32'h8000_0000;
      3: return $urandom;
      default: return $urandom_range(0, 8191);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    mem[1] = 32'hDEADBEEF;
    mem[2047] = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    cyc(1, 32'h4, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    repeat (8) cyc(1, 32'h10, 1, 1, 32'h20, 1);
    cyc(0, 0, 1, 0, 0, 1);
    repeat (2) cyc(0, 0, 1, 1, 32'h2000, 1);
    repeat (2) cyc(0, 0, 1, 1, 32'h8000_0000, 1);
    repeat (2) cyc(0, 0, 1, 1, 32'h1FFC, 1);
    cyc(1, 32'h8, 0, 1, 32'h30, 1);
    repeat (5) cyc(0, 0, 0, 1, 32'h30, 1);
    cyc(0, 0, 1, 1, 32'h30, 1);
    cyc(0, 0, 1, 1, 32'h30, 1);
    cyc(0, 0, 1, 0, 0, 1);
    cyc(0, 0, 1, 1, 32'h2000, 0);
    reset = 1;
    cyc(0, 0, 0, 0, 0, 0);
    reset = 0;
    cyc(1, 32'h40, 1, 1, 32'h44, 1);
    cyc(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 1), rnd_addr(), $urandom_range(0, 9) < 7,
          $urandom_range(0, 1), rnd_addr(), $urandom_range(0, 9) < 7);
    for (int i = 0; i < 300; i++) cyc(0, 0, 1, 1, (i % 2) ? 32'h2000 : 32'hFFFF_FFF0, 1);
    repeat (3) cyc(0, 0, 1, 0, 0, 1);
    chk("err_count_sat", err_count, EMAX);
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single-port, 8 KB instruction ROM between two requesters: instruction fetch (IF) and load/store constant reads (LS).
- Each requester has its own valid/ready request channel and valid/ready response channel.
- Uses round-robin arbitration and allows one outstanding ROM access at a time.
- Checks address bounds and drives the ROM's registered read port (1-cycle read latency, read data held until the next enable).

Parameters:
- ADDR_WIDTH, 32, byte-address width of request and ROM address.
- DATA_WIDTH, 32, ROM word width.
- ROM_BYTES, 8192, ROM size in bytes; any address >= ROM_BYTES is out of bounds.
- ERRCNT_WIDTH, 16, width of the saturating out-of-bounds error counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req_valid  in  1  IF request valid.
- if_req_ready  out  1  IF request accepted this cycle.
- if_req_addr  in  ADDR_WIDTH  IF byte address.
- if_rsp_valid  out  1  IF response valid.
- if_rsp_ready  in  1  IF ready to take the response.
- if_rsp_data  out  DATA_WIDTH  IF read word.
- if_rsp_err  out  1  IF out-of-bounds flag.
- ls_req_valid / ls_req_ready / ls_req_addr / ls_rsp_valid / ls_rsp_ready / ls_rsp_data / ls_rsp_err: same directions, widths and meaning as the IF ports, for the LS requester.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_WIDTH  ROM byte address; the ROM drops bits [1:0].
- rom_data  in  DATA_WIDTH  ROM registered read data.
- err_count  out  ERRCNT_WIDTH  saturating count of out-of-bounds requests.

Behaviour:
- States:
  - IDLE: accept one request.
  - RESP: hold the response until the owning requester takes it.
- Reset (synchronous, active-high):
  - state=IDLE; all *_req_ready=0, *_rsp_valid=0, *_rsp_err=0, *_rsp_data=0; rom_en=0, rom_addr=0; err_count=0.
  - last_grant=LS, so IF wins the first tie.
  - Reset asserted mid-transaction drops the pending response with no handshake; rsp_valid is 0 from the cycle after reset is sampled.
- IDLE grant:
  - Only one valid requester: grant it.
  - Both valid: grant the one not equal to last_grant.
  - Grant is combinational: granted *_req_ready=1 in the same cycle; the other ready=0; ready never asserts in RESP.
- On accept (valid&&ready, cycle T):
  - Register owner and err = (addr >= ROM_BYTES); update last_grant; next state=RESP.
  - In-bounds: rom_en=1 and rom_addr=req_addr combinationally in cycle T.
  - Out-of-bounds: rom_en=0 and err_count increments, saturating at all-ones.
- rom_en is 1 only in an in-bounds accept cycle, else 0; rom_addr is 0 when rom_en=0.
- RESP, from T+1:
  - Owner's rsp_valid=1; rsp_data = err ? 0 : rom_data (ROM output is stable because rom_en=0 throughout RESP); rsp_err=err.
  - Non-owner rsp_valid=0, data=0.
- Response handshake:
  - Held stable until owner rsp_valid&&rsp_ready; then next state=IDLE.
  - No new accept in the same cycle as the response handshake.
  - Minimum 2 cycles per transaction; latency accept→rsp_valid = 1 cycle.
- Address handling:
  - addr[1:0] are ignored; the full word is returned.
  - ROM_BYTES-4 (0x1FFC) is in bounds; ROM_BYTES (0x2000) and any nonzero address bit at or above bit 13 (e.g. 0x8000_0000) are out of bounds.
- A requester dropping valid before acceptance is legal; no state changes.

Test Plan:
- Reset, then IF only, addr 0x0000_0004 with ROM word1=0xDEADBEEF, if_rsp_ready=1 → if_req_ready=1 in T, rom_en=1/rom_addr=4 in T, if_rsp_valid=1 with data 0xDEADBEEF and err=0 at T+1, IDLE at T+2.
- Both valid continuously, IF addr 0x10, LS addr 0x20, both rsp_ready=1 → grants alternate IF, LS, IF, LS; each response on the correct port with the matching word; no ready during RESP.
- LS addr 0x0000_2000, then 0x8000_0000 → rom_en stays 0, ls_rsp_err=1 with data=0 one cycle after each accept; err_count=2; address 0x1FFC returns the last word with err=0.
- IF response with if_rsp_ready=0 for 5 cycles while LS is valid → if_rsp_valid/data held stable, ls_req_ready=0 throughout; LS accepted the cycle after the IF handshake completes.
- Reset pulsed while in RESP → rsp_valid=0 the next cycle, err_count=0, next request with both valid grants IF.
- Force 0xFFFF out-of-bounds requests, then one more → err_count saturates at 0xFFFF.
